// File: rtl/and_gate_sync_if.sv
// Operand/result bundle for and_gate_sync: the master drives operands and controls,
// the slave (the AND unit) drives the combinational and registered results.
interface and_gate_sync_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  // Handshake: in_valid qualifies a and b for the current edge. There is no ready,
  // so every valid operation is accepted. out_valid pulses once per accepted operation,
  // one edge later, and y_q/all_ones/any_one are meaningful while it is high.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             clr;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic             out_valid;
  logic             all_ones;
  logic             any_one;
  logic [3:0]       cov;
  logic             cov_full;
  logic [CNT_W-1:0] op_count;

  modport master (
    output a, b, in_valid, clr,
    input  y, y_q, out_valid, all_ones, any_one, cov, cov_full, op_count
  );

  modport slave (
    input  a, b, in_valid, clr,
    output y, y_q, out_valid, all_ones, any_one, cov, cov_full, op_count
  );
endinterface

// File: rtl/and_gate_sync.sv
// Bitwise AND unit with a combinational result, a registered result qualified by
// out_valid, reduction flags, a lane-0 truth-table coverage bitmap and a saturating op counter.
module and_gate_sync #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  and_gate_sync_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] and_res;
  logic [1:0]       lane0;

  logic [WIDTH-1:0] y_q_q, y_q_d;
  logic             out_valid_q, out_valid_d;
  logic             all_ones_q, all_ones_d;
  logic             any_one_q, any_one_d;
  logic [3:0]       cov_q, cov_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  assign and_res = bus.a & bus.b;
  assign lane0   = {bus.a[0], bus.b[0]};

  // Capture path: result registers hold when no operation is offered.
  always_comb begin
    y_q_d       = y_q_q;
    all_ones_d  = all_ones_q;
    any_one_d   = any_one_q;
    out_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      y_q_d      = and_res;
      all_ones_d = &and_res;
      any_one_d  = |and_res;
    end
  end

  // clr wins over in_valid here only; the capture path above ignores clr.
  always_comb begin
    cov_d      = cov_q;
    op_count_d = op_count_q;
    if (bus.clr) begin
      cov_d      = 4'b0000;
      op_count_d = '0;
    end else if (bus.in_valid) begin
      cov_d[lane0] = 1'b1;
      if (op_count_q != CNT_MAX) begin
        op_count_d = op_count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q_q       <= '0;
      out_valid_q <= 1'b0;
      all_ones_q  <= 1'b0;
      any_one_q   <= 1'b0;
      cov_q       <= 4'b0000;
      op_count_q  <= '0;
    end else begin
      y_q_q       <= y_q_d;
      out_valid_q <= out_valid_d;
      all_ones_q  <= all_ones_d;
      any_one_q   <= any_one_d;
      cov_q       <= cov_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.y         = and_res;
  assign bus.y_q       = y_q_q;
  assign bus.out_valid = out_valid_q;
  assign bus.all_ones  = all_ones_q;
  assign bus.any_one   = any_one_q;
  assign bus.cov       = cov_q;
  assign bus.cov_full  = (cov_q == 4'b1111);
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_and_gate_sync.sv
// Bench for and_gate_sync: a WIDTH=1/CNT_W=16 and a WIDTH=8/CNT_W=3 instance share
// clock, reset and controls, and are compared against a behavioural model.
module tb_and_gate_sync;
  logic clk;
  logic rst_n;

  and_gate_sync_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
  and_gate_sync_if #(.WIDTH(8), .CNT_W(3))  bus8 ();

  and_gate_sync #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  and_gate_sync #(.WIDTH(8), .CNT_W(3))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  // Clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic       m_yq1, m_ov1, m_all1, m_any1;
  logic [7:0] m_yq8;
  logic       m_ov8, m_all8, m_any8;
  bit         seen1[4];
  bit         seen8[4];
  int         cnt1, cnt8;
  logic [7:0] exp_q[$];

  function automatic logic [3:0] cov_of(input bit s0, input bit s1, input bit s2, input bit s3);
    cov_of = {s3, s2, s1, s0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_yq1 = 0; m_ov1 = 0; m_all1 = 0; m_any1 = 0;
    m_yq8 = 0; m_ov8 = 0; m_all8 = 0; m_any8 = 0;
    for (int i = 0; i < 4; i++) begin
      seen1[i] = 0;
      seen8[i] = 0;
    end
    cnt1 = 0;
    cnt8 = 0;
    exp_q.delete();
  endtask

  // Driver: apply one cycle of stimulus, check y, clock, update model, check registers.
  task automatic step(input logic rst, input logic clr, input logic vld,
                      input logic a1, input logic b1, input logic [7:0] a8, input logic [7:0] b8);
    logic [7:0] r8;
    logic [3:0] c1, c8;
    logic [7:0] popped;
    rst_n = rst;
    bus1.clr = clr; bus1.in_valid = vld; bus1.a = a1; bus1.b = b1;
    bus8.clr = clr; bus8.in_valid = vld; bus8.a = a8; bus8.b = b8;
    #1;
    check("y_w1", bus1.y, (a1 == 1'b1 && b1 == 1'b1) ? 64'd1 : 64'd0);
    r8 = 8'h00;
    for (int i = 0; i < 8; i++) if (a8[i] == 1'b1 && b8[i] == 1'b1) r8 = r8 + 8'(1 << i);
    check("y_w8", bus8.y, r8);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      m_ov1 = vld;
      m_ov8 = vld;
      if (vld) begin
        m_yq1 = a1 && b1;
        m_all1 = m_yq1;
        m_any1 = m_yq1;
        m_yq8 = r8;
        m_all8 = (r8 == 8'd255);
        m_any8 = (r8 != 8'd0);
        exp_q.push_back(r8);
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) begin
          seen1[i] = 0;
          seen8[i] = 0;
        end
        cnt1 = 0;
        cnt8 = 0;
      end else if (vld) begin
        seen1[2 * int'(a1) + int'(b1)] = 1;
        seen8[2 * int'(a8[0]) + int'(b8[0])] = 1;
        cnt1 = (cnt1 + 1 > 65535) ? 65535 : cnt1 + 1;
        cnt8 = (cnt8 + 1 > 7) ? 7 : cnt8 + 1;
      end
    end
    #1;
    c1 = cov_of(seen1[0], seen1[1], seen1[2], seen1[3]);
    c8 = cov_of(seen8[0], seen8[1], seen8[2], seen8[3]);
    check("y_q_w1", bus1.y_q, m_yq1);
    check("out_valid_w1", bus1.out_valid, m_ov1);
    check("all_ones_w1", bus1.all_ones, m_all1);
    check("any_one_w1", bus1.any_one, m_any1);
    check("cov_w1", bus1.cov, c1);
    check("cov_full_w1", bus1.cov_full, c1 == 4'hF);
    check("op_count_w1", bus1.op_count, cnt1);
    check("y_q_w8", bus8.y_q, m_yq8);
    check("out_valid_w8", bus8.out_valid, m_ov8);
    check("all_ones_w8", bus8.all_ones, m_all8);
    check("any_one_w8", bus8.any_one, m_any8);
    check("cov_w8", bus8.cov, c8);
    check("cov_full_w8", bus8.cov_full, c8 == 4'hF);
    check("op_count_w8", bus8.op_count, cnt8);
    // Scoreboard: every out_valid pulse consumes exactly one expected capture.
    if (m_ov8) begin
      if (exp_q.size() == 0) begin
        check("sb_empty_w8", 64'd1, 64'd0);
      end else begin
        popped = exp_q.pop_front();
        check("sb_y_q_w8", bus8.y_q, popped);
      end
    end
  endtask

  initial begin
    model_reset();
    // Reset state
    step(0, 0, 0, 0, 0, 8'h00, 8'h00);
    step(0, 0, 1, 1, 1, 8'hFF, 8'hFF);
    // Truth table on lane 0 / WIDTH=1
    step(1, 0, 1, 0, 0, 8'h00, 8'h00);
    step(1, 0, 1, 0, 1, 8'h00, 8'h01);
    step(1, 0, 1, 1, 0, 8'h01, 8'h00);
    step(1, 0, 1, 1, 1, 8'h01, 8'h01);
    check("tt_cov_full_w1", bus1.cov_full, 64'd1);
    check("tt_op_count_w1", bus1.op_count, 64'd4);
    // Reset mid-stream discards the pending result; y stays combinational
    step(1, 0, 1, 1, 1, 8'hFF, 8'hFF);
    step(0, 0, 1, 1, 1, 8'hFF, 8'hFF);
    check("rst_op_count_w8", bus8.op_count, 64'd0);
    // Wide operands
    step(1, 0, 1, 0, 0, 8'hF0, 8'h3C);
    check("wide_y_q", bus8.y_q, 64'h30);
    step(1, 0, 1, 1, 1, 8'hFF, 8'hFF);
    check("wide_all_ones", bus8.all_ones, 64'd1);
    // Valid gating: inputs change, registers hold
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    // clr collides with in_valid
    step(1, 1, 1, 1, 0, 8'h5A, 8'h0F);
    check("clr_out_valid_w8", bus8.out_valid, 64'd1);
    // Saturation on the CNT_W=3 instance
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    check("sat_op_count_w8", bus8.op_count, 64'd7);
    // Randomized mix
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/and_gate_sync.md
Name: and_gate_sync

Overview:
- Parameterized bitwise AND unit with two output paths.
- Combinational output y = a & b is always valid, with zero latency.
- Registered output y_q carries the same result, qualified by valid, for pipelined consumers.
- Includes reduction flags and a lane-0 truth-table coverage monitor for bring-up and self-check of the logic-gate practice blocks.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- CNT_W, 16, width of the saturating operation counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  marks a and b as a valid operation this cycle.
- clr  input  1  synchronous clear of the coverage bitmap and counter; outputs are unaffected.
- y  output  WIDTH  combinational a & b.
- y_q  output  WIDTH  registered a & b, captured when in_valid=1.
- out_valid  output  1  y_q holds a result captured on the previous edge.
- all_ones  output  1  registered: &(a & b) of the last captured operation.
- any_one  output  1  registered: |(a & b) of the last captured operation.
- cov  output  4  lane-0 combinations seen; bit index = {a[0],b[0]} (bit0=00, bit1=01, bit2=10, bit3=11).
- cov_full  output  1  cov == 4'b1111.
- op_count  output  CNT_W  number of valid operations, saturating.

Behaviour:
- y = a & b, purely combinational.
  - No clock dependency; independent of rst_n, in_valid and clr.
  - Settles within the same delta after any a or b change.
- Reset (rst_n=0 at a rising edge) forces y_q=0, out_valid=0, all_ones=0, any_one=0, cov=0, op_count=0.
  - Reset has priority over in_valid and clr.
  - Reset asserted mid-stream discards the pending result.
- Capture path, at an edge with rst_n=1:
  - If in_valid=1: y_q <= a & b, all_ones <= &(a&b), any_one <= |(a&b), out_valid <= 1.
  - If in_valid=0: out_valid <= 0; y_q, all_ones and any_one hold their previous values.
  - Latency is exactly 1 cycle from valid input to out_valid.
  - out_valid is high for one cycle per valid input; back-to-back valids give continuous out_valid with no bubbles.
- Coverage and counter, at an edge with rst_n=1:
  - clr=1: cov <= 0 and op_count <= 0. clr takes priority over a simultaneous in_valid for these registers only; the capture path still captures.
  - Otherwise, when in_valid=1: cov[{a[0],b[0]}] <= 1, and op_count increments by 1.
  - op_count saturates at 2^CNT_W-1 with no wrap.
- cov_full is combinational from cov.
- No X propagation: all registers have defined reset values. Inputs are assumed known when in_valid=1.
- WIDTH=1 degenerates to a single gate: all_ones == any_one == y_q.

Test Plan:
- Truth table, WIDTH=1: a,b = 00,01,10,11, each held 10 ns, in_valid=1 -> y = 0,0,0,1 combinationally in each window.
  - y_q and out_valid follow one edge later.
  - After the 4th capture, cov=4'b1111, cov_full=1, op_count=4.
- Reset: drive in_valid=1 with a=b=1, then assert rst_n=0 for one edge -> y_q=0, out_valid=0, cov=0, op_count=0; y is still 1.
- Wide operands, WIDTH=8: a=8'hF0, b=8'h3C -> y=8'h30.
  - Next edge: y_q=8'h30, any_one=1, all_ones=0.
  - a=b=8'hFF -> all_ones=1.
- Valid gating: in_valid=0 with changing a and b -> y tracks a & b; y_q holds, out_valid=0, and op_count is unchanged.
- Clear vs. valid collision: clr=1 and in_valid=1 on the same edge -> cov=0 and op_count=0, while y_q is updated and out_valid=1.
- Saturation, CNT_W=3: 10 consecutive valid operations -> op_count stops at 7.
